// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the button play detector: state codes, default debounce length, one-hot test.
package detector_jogada_pkg;

  localparam int DEBOUNCE_DEFAULT = 50000;

  typedef enum logic [3:0] {
    ESPERA      = 4'd0,
    ESTABILIZA  = 4'd1,
    PRESSIONADO = 4'd2,
    LIBERA      = 4'd3
  } estado_t;

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/contador_debounce.sv
// Saturating debounce counter with clear/enable; fim flags the last cycle of the stability window.
module contador_debounce
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic fim
);

  localparam int W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [W-1:0] cnt;

  assign fim = (cnt == W'(DEBOUNCE_CYCLES - 1));

  // Holding at the terminal value keeps the counter from ever wrapping.
  always_ff @(posedge clock) begin
    if (reset || clr)   cnt <= '0;
    else if (en && !fim) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/detector_jogada.sv
// Debounces the buttons and emits one registered play per single-button press.
// Optional DETECTOR_JOGADA_SYNC_EN adds a 2-flop input synchronizer (2 cycles extra latency).
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int N_BOTOES        = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_feita,
  output logic                multiplo,
  output logic                db_tem_jogada,
  output logic [3:0]          db_estado
);

  logic [N_BOTOES-1:0] botoes_s;

`ifdef DETECTOR_JOGADA_SYNC_EN
  logic [N_BOTOES-1:0] sync1, sync2;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= botoes;
      sync2 <= sync1;
    end
  end
  assign botoes_s = sync2;
`else
  assign botoes_s = botoes;
`endif

  estado_t             estado, prox;
  logic [N_BOTOES-1:0] candidato;
  logic                clr, en, fim, carrega_cand, carrega_jogada, feita_d, mult_d;

  contador_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .fim   (fim)
  );

  always_comb begin
    prox           = estado;
    clr            = 1'b0;
    en             = 1'b0;
    carrega_cand   = 1'b0;
    carrega_jogada = 1'b0;
    feita_d        = 1'b0;
    mult_d         = 1'b0;
    case (estado)
      ESPERA: begin
        if (habilita && (botoes_s != '0)) begin
          carrega_cand = 1'b1;
          clr          = 1'b1;
          prox         = ESTABILIZA;
        end
      end
      ESTABILIZA: begin
        if (botoes_s != candidato) begin
          clr  = 1'b1;
          prox = ESPERA;
        end else if (fim) begin
          prox = PRESSIONADO;
          if (!is_onehot(32'(candidato))) mult_d = 1'b1;
          else if (habilita) begin
            feita_d        = 1'b1;
            carrega_jogada = 1'b1;
          end
        end else begin
          en = 1'b1;
        end
      end
      PRESSIONADO: begin
        if (botoes_s == '0) begin
          clr  = 1'b1;
          prox = LIBERA;
        end
      end
      LIBERA: begin
        // A nonzero sample here is release bounce: go back to held without a new pulse.
        if (botoes_s != '0) prox = PRESSIONADO;
        else if (fim)       prox = ESPERA;
        else                en   = 1'b1;
      end
      default: prox = ESPERA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= ESPERA;
      candidato    <= '0;
      jogada       <= '0;
      jogada_feita <= 1'b0;
      multiplo     <= 1'b0;
    end else begin
      estado       <= prox;
      jogada_feita <= feita_d;
      multiplo     <= mult_d;
      if (carrega_cand)   candidato <= botoes_s;
      if (carrega_jogada) jogada    <= candidato;
    end
  end

  assign db_tem_jogada = (estado == PRESSIONADO) || (estado == LIBERA);
  assign db_estado     = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench: directed scenarios plus random button traffic against a run-length reference model.
module tb_detector_jogada;

  localparam int D = 4;
  localparam int N = 4;
`ifdef DETECTOR_JOGADA_SYNC_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = D;
`endif

  logic         clock = 1'b0;
  logic         reset, habilita;
  logic [N-1:0] botoes, jogada;
  logic         jogada_feita, multiplo, db_tem_jogada;
  logic [3:0]   db_estado;

  always #5 clock = ~clock;

  detector_jogada #(.DEBOUNCE_CYCLES(D), .N_BOTOES(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .botoes        (botoes),
    .habilita      (habilita),
    .jogada        (jogada),
    .jogada_feita  (jogada_feita),
    .multiplo      (multiplo),
    .db_tem_jogada (db_tem_jogada),
    .db_estado     (db_estado)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a press is accepted once a nonzero value sampled while idle
  // stays unchanged for D more samples; re-arm needs D+1 consecutive zero samples.
  bit           m_armed;
  int           m_start, m_zero, t;
  logic [N-1:0] m_cand, m_jog, s1, s2;
  bit           m_feita, m_mult;

  task automatic model_step(input logic rst, input logic [N-1:0] b_in, input logic h);
    logic [N-1:0] b;
    if (rst) begin
      m_armed = 1; m_start = -1; m_zero = 0; m_cand = '0; m_jog = '0;
      s1 = '0; s2 = '0; m_feita = 0; m_mult = 0; t++;
      return;
    end
`ifdef DETECTOR_JOGADA_SYNC_EN
    b = s2; s2 = s1; s1 = b_in;
`else
    b = b_in;
`endif
    m_feita = 0; m_mult = 0;
    if (m_armed) begin
      if (m_start < 0) begin
        if (h && b != '0) begin m_start = t; m_cand = b; end
      end else if (b != m_cand) begin
        m_start = -1;
      end else if (t - m_start == D) begin
        m_armed = 0; m_zero = 0; m_start = -1;
        if ($countones(m_cand) != 1) m_mult = 1;
        else if (h) begin m_feita = 1; m_jog = m_cand; end
      end
    end else if (b == '0) begin
      m_zero++;
      if (m_zero == D + 1) m_armed = 1;
    end else begin
      m_zero = 0;
    end
    t++;
  endtask

  function automatic int exp_estado();
    if (m_armed) return (m_start < 0) ? 0 : 1;
    return (m_zero > 0) ? 3 : 2;
  endfunction

  int pulses, mults, pulse_at, idx;

  task automatic cyc(input logic [N-1:0] b, input logic h, input logic rst = 1'b0);
    botoes = b; habilita = h; reset = rst;
    @(posedge clock);
    model_step(rst, b, h);
    #1;
    check("jogada",        32'(jogada),        32'(m_jog));
    check("jogada_feita",  32'(jogada_feita),  32'(m_feita));
    check("multiplo",      32'(multiplo),      32'(m_mult));
    check("db_tem_jogada", 32'(db_tem_jogada), 32'(!m_armed));
    check("db_estado",     32'(db_estado),     32'(exp_estado()));
    if (jogada_feita) begin pulses++; if (pulse_at < 0) pulse_at = idx; end
    if (multiplo) mults++;
    idx++;
  endtask

  task automatic mark();
    pulses = 0; mults = 0; pulse_at = -1; idx = 0;
  endtask

  initial begin
    t = 0;
    cyc('0, 1'b1, 1'b1);
    cyc('0, 1'b1, 1'b1);
    check("reset_estado", 32'(db_estado), 32'd0);
    check("reset_jogada", 32'(jogada), 32'd0);

    // 1: clean press held 20 cycles
    mark();
    repeat (20) cyc(4'b0010, 1'b1);
    check("s1_latency", 32'(pulse_at), 32'(LAT));
    check("s1_pulses", 32'(pulses), 32'd1);
    check("s1_jogada", 32'(jogada), 32'h2);
    repeat (D + 4) cyc('0, 1'b1);

    // 2: bouncy press
    mark();
    repeat (2) cyc(4'b0010, 1'b1);
    cyc('0, 1'b1);
    mark();
    repeat (15) cyc(4'b0010, 1'b1);
    check("s2_latency", 32'(pulse_at), 32'(LAT));
    check("s2_pulses", 32'(pulses), 32'd1);
    repeat (D + 4) cyc('0, 1'b1);

    // 3: multi-button press, then 1000
    mark();
    repeat (12) cyc(4'b0101, 1'b1);
    check("s3_mult", 32'(mults), 32'd1);
    check("s3_nofeita", 32'(pulses), 32'd0);
    check("s3_jogada_kept", 32'(jogada), 32'h2);
    repeat (D + 4) cyc('0, 1'b1);
    repeat (12) cyc(4'b1000, 1'b1);
    check("s3_jogada_new", 32'(jogada), 32'h8);
    repeat (D + 4) cyc('0, 1'b1);

    // 4: release bounce
    mark();
    repeat (12) cyc(4'b0001, 1'b1);
    repeat (2) cyc('0, 1'b1);
    cyc(4'b0001, 1'b1);
    repeat (D + 4) cyc('0, 1'b1);
    check("s4_pulses", 32'(pulses), 32'd1);

    // 5: habilita low, then raised while held
    mark();
    repeat (10) cyc(4'b0100, 1'b0);
    check("s5_nopulse", 32'(pulses), 32'd0);
    check("s5_espera", 32'(db_estado), 32'd0);
    mark();
    repeat (12) cyc(4'b0100, 1'b1);
    check("s5_latency", 32'(pulse_at), 32'(LAT));
    repeat (D + 4) cyc('0, 1'b1);

    // 6: reset in the middle of stabilisation
    repeat (LAT - 1) cyc(4'b0010, 1'b1);
    cyc(4'b0010, 1'b1, 1'b1);
    check("s6_estado", 32'(db_estado), 32'd0);
    check("s6_jogada", 32'(jogada), 32'd0);
    check("s6_feita", 32'(jogada_feita), 32'd0);
    repeat (D + 4) cyc('0, 1'b1);

    // Random traffic: held segments of random values, occasional habilita drop and reset
    for (int seg = 0; seg < 400; seg++) begin
      logic [N-1:0] v;
      logic         h;
      int           len;
      case ($urandom_range(0, 3))
        0:       v = '0;
        1, 2:    v = N'(1) << $urandom_range(0, N - 1);
        default: v = N'($urandom);
      endcase
      h   = ($urandom_range(0, 5) != 0);
      len = $urandom_range(1, 2 * D + 3);
      for (int k = 0; k < len; k++) cyc(v, h, ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
Button-conditioning stage directly upstream of the game datapath (fluxo_dados) and control unit.
- Debounces the 4 raw push-buttons.
- Accepts only single-button presses.
- Emits a registered one-hot play code plus a one-cycle jogada_feita pulse per accepted press.
- Press-and-hold produces exactly one pulse; the buttons must be released, and the release debounced, before the next press is accepted.

Parameters:
DEBOUNCE_CYCLES, 50000, clocks an input level must hold stable to be accepted (1 ms at 50 MHz); legal range ≥1.
N_BOTOES, 4, number of button inputs; one-hot code width.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
botoes  in  N_BOTOES  raw buttons, 1 = pressed
habilita  in  1  control unit allows a new play to be accepted
jogada  out  N_BOTOES  last accepted one-hot play, registered
jogada_feita  out  1  one-cycle pulse, play accepted
multiplo  out  1  one-cycle pulse, debounced multi-button press rejected
db_tem_jogada  out  1  1 while any debounced button is held (states PRESSIONADO/LIBERA)
db_estado  out  4  current FSM state code

Behaviour:
- Reset (synchronous, active-high, overrides everything): state ESPERA, counter 0, candidate 0, jogada 0, jogada_feita 0, multiplo 0, db_tem_jogada 0.
- botoes_s: the sampled button vector. Equals botoes directly, or the synchronizer output when the optional feature is enabled.
- ESPERA (code 0):
  - If habilita=1 and botoes_s≠0: candidate←botoes_s, cnt←0, go ESTABILIZA.
  - Otherwise remain in ESPERA.
- ESTABILIZA (code 1):
  - If botoes_s≠candidate: cnt←0, go ESPERA. No pulse.
  - Else if cnt=DEBOUNCE_CYCLES-1, go PRESSIONADO and:
    - candidate one-hot and habilita=1: jogada←candidate, jogada_feita=1 for one cycle.
    - candidate not one-hot: multiplo=1 for one cycle; jogada unchanged.
    - candidate one-hot, habilita=0: no pulse; jogada unchanged.
  - Else cnt←cnt+1.
- PRESSIONADO (code 2):
  - If botoes_s=0: cnt←0, go LIBERA.
  - Any change among nonzero values is ignored; no new pulse.
- LIBERA (code 3):
  - If botoes_s≠0: go PRESSIONADO (bounce on release).
  - Else if cnt=DEBOUNCE_CYCLES-1: go ESPERA.
  - Else cnt←cnt+1.
- Latency: a value first seen on botoes_s in cycle 0 while in ESPERA gives jogada_feita high in cycle DEBOUNCE_CYCLES+1. jogada is updated in that same cycle.
- Pulses:
  - jogada_feita and multiplo are registered and never high together.
  - Each is never high for more than one consecutive cycle.
- jogada holds its value until the next accepted play or reset.
- Counter width: clog2(DEBOUNCE_CYCLES)+1 bits; the counter never wraps.
- Illegal state codes go to ESPERA on the next clock.

Optional Feature:
DETECTOR_JOGADA_SYNC_EN
- Defined: a 2-flop synchronizer per button feeds botoes_s. Adds exactly 2 cycles of latency, so the pulse appears at DEBOUNCE_CYCLES+3. The synchronizer flops reset to 0.
- Undefined: botoes_s=botoes, with no added latency.

Decomposition:
- Package detector_jogada_pkg holds:
  - state encoding constants: ESPERA=0, ESTABILIZA=1, PRESSIONADO=2, LIBERA=3;
  - default DEBOUNCE_CYCLES;
  - an is_onehot function.
- One sub-module, contador_debounce: counter with clear, enable and terminal-count output (fim). It is reused for both the ESTABILIZA and LIBERA phases.
- FSM and output registers stay in detector_jogada.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, SYNC disabled, habilita=1 unless stated.)
1. Clean press: botoes 0000→0010, held for 20 cycles. Expect jogada_feita high exactly in cycle 5 after the edge, jogada=0010, and a single pulse over the whole hold.
2. Bouncy press: 0010 for 2 cycles, 0000 for 1, then 0010 held. Expect no pulse from the first burst and exactly one pulse 5 cycles after the final rising edge.
3. Multi-button press: 0101 held. Expect multiplo pulse in cycle 5, no jogada_feita, jogada keeps its prior value. After release, a subsequent 1000 press yields jogada=1000.
4. Release bounce: after an accepted 0001, drop to 0000 for 2 cycles, back to 0001 for 1, then 0000. Expect no second pulse, and ESPERA reached only after 4 stable-zero cycles.
5. habilita=0 throughout a 0100 press: no pulse and state stays ESPERA. Raising habilita while still held yields a pulse 5 cycles later.
6. Reset mid-ESTABILIZA: assert reset for 1 cycle. Next cycle shows state 0, jogada=0, no pulse. With DETECTOR_JOGADA_SYNC_EN defined, repeat scenario 1 and expect the pulse in cycle 7.
